// File: rtl/subservient_sram_pkg.sv
// Shared helpers and types for the subservient narrow-port to OpenRAM bank bridge.
// Holds the default geometry, bank/field-width helpers and the buffer control struct.
// Optional read-register stage is selected in the top by SRAM_RDREG_EN.
package subservient_sram_pkg;

  localparam int DEF_MEMSIZE  = 8192;
  localparam int DEF_NARROW_W = 8;
  localparam int DEF_MACRO_DW = 32;
  localparam int DEF_MACRO_AW = 8;

  // Number of macros needed to cover memsize bytes
  function automatic int bank_count(input int memsize, input int macro_dw, input int macro_aw);
    return (memsize * 8) / (macro_dw << macro_aw);
  endfunction

  // Index bits needed to select one of n items; zero when there is only one
  function automatic int field_bits(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Narrow unit that owns a given byte lane of the macro word
  function automatic int lane_unit(input int lane, input int narrow_w);
    return lane / (narrow_w / 8);
  endfunction

  // Derived widths for the default geometry
  localparam int U  = DEF_MACRO_DW / DEF_NARROW_W;
  localparam int NB = bank_count(DEF_MEMSIZE, DEF_MACRO_DW, DEF_MACRO_AW);
  localparam int AW = $clog2(DEF_MEMSIZE * 8 / DEF_NARROW_W);
  localparam int WM = DEF_MACRO_DW / 8;

  // Per-cycle decision of the write-combining buffer
  typedef struct packed {
    logic hit;    // incoming write lands in the buffered word
    logic flush;  // buffered word goes out on port0 this cycle
    logic load;   // incoming write starts a new buffered word
  } wc_ctl_t;

endpackage

// File: rtl/subservient_sram_wcomb.sv
// Write-combining buffer: merges narrow writes to one macro word, flushes as one masked port0 write.
// Flush is combinational from the buffer registers in the cycle the buffer is left; loads same cycle.
// No backpressure: one narrow write accepted every cycle, at most one macro write per cycle.
module subservient_sram_wcomb
  import subservient_sram_pkg::*;
#(
  parameter int NARROW_W = 8,
  parameter int MACRO_DW = 32,
  parameter int MACRO_AW = 8,
  parameter int NBK      = 8,
  parameter int NU       = 4,
  parameter int UW       = 2,
  parameter int BW       = 3,
  parameter int WORD_W   = 11,
  parameter int WMW      = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wen,
  input  logic [WORD_W-1:0]   i_wword,
  input  logic [UW-1:0]       i_wunit,
  input  logic [NARROW_W-1:0] i_wdata,
  output logic                o_buf_valid,
  output logic [WORD_W-1:0]   o_buf_word,
  output logic [MACRO_DW-1:0] o_buf_data,
  output logic [NU-1:0]       o_buf_umask,
  output logic [NBK-1:0]      o_csb0,
  output logic [WMW-1:0]      o_wmask0,
  output logic [MACRO_AW-1:0] o_addr0,
  output logic [MACRO_DW-1:0] o_din0
);

  logic                r_buf_valid;
  logic [WORD_W-1:0]   r_buf_word;
  logic [MACRO_DW-1:0] r_buf_data;
  logic [NU-1:0]       r_buf_umask;
  logic [MACRO_AW-1:0] r_addr0;
  logic [MACRO_DW-1:0] r_din0;
  logic [WMW-1:0]      r_wmask0;

  wc_ctl_t             w_ctl;
  logic [NU-1:0]       w_onehot;
  logic [BW-1:0]       w_bank;
  logic [WMW-1:0]      w_wmask_exp;

  assign w_onehot = NU'(1) << i_wunit;

  if (NBK > 1) begin : g_bank
    assign w_bank = r_buf_word[WORD_W-1:MACRO_AW];
  end else begin : g_nobank
    assign w_bank = '0;
  end

  // Each narrow-unit mask bit covers NARROW_W/8 byte lanes
  for (genvar l = 0; l < WMW; l++) begin : g_lane
    localparam int LU = lane_unit(l, NARROW_W);
    assign w_wmask_exp[l] = r_buf_umask[LU];
  end

  // Decide merge / flush / load; reset suppresses any flush of discarded data
  always_comb begin
    w_ctl       = '0;
    w_ctl.hit   = i_wen & r_buf_valid & (i_wword == r_buf_word);
    w_ctl.flush = r_buf_valid & ~w_ctl.hit & ~i_rst;
    w_ctl.load  = i_wen & ~w_ctl.hit;
  end

  // Port0 carries the buffered word on a flush, otherwise holds its last values
  always_comb begin
    o_csb0   = '1;
    o_addr0  = r_addr0;
    o_din0   = r_din0;
    o_wmask0 = r_wmask0;
    if (w_ctl.flush) begin
      o_csb0   = ~(NBK'(1) << w_bank);
      o_addr0  = r_buf_word[MACRO_AW-1:0];
      o_din0   = r_buf_data;
      o_wmask0 = w_wmask_exp;
    end
  end

  // Buffer update: merge into current word, or start a new one, or drain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf_valid <= 1'b0;
      r_buf_word  <= '0;
      r_buf_data  <= '0;
      r_buf_umask <= '0;
    end else if (w_ctl.hit) begin
      r_buf_umask <= r_buf_umask | w_onehot;
      r_buf_data[i_wunit*NARROW_W +: NARROW_W] <= i_wdata;
    end else if (w_ctl.load) begin
      r_buf_valid <= 1'b1;
      r_buf_word  <= i_wword;
      r_buf_umask <= w_onehot;
      r_buf_data[i_wunit*NARROW_W +: NARROW_W] <= i_wdata;
    end else begin
      r_buf_valid <= 1'b0;
    end
  end

  // Remember the last port0 write so idle cycles hold address/data/mask
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr0  <= '0;
      r_din0   <= '0;
      r_wmask0 <= '0;
    end else if (w_ctl.flush) begin
      r_addr0  <= o_addr0;
      r_din0   <= o_din0;
      r_wmask0 <= o_wmask0;
    end
  end

  assign o_buf_valid = r_buf_valid;
  assign o_buf_word  = r_buf_word;
  assign o_buf_data  = r_buf_data;
  assign o_buf_umask = r_buf_umask;

endmodule

// File: rtl/subservient_sram_bridge.sv
// Bridge from the subservient narrow SRAM port to NB banks of 1rw1r macros (writes port0, reads port1).
// Read latency T+1, or T+2 when SRAM_RDREG_EN is defined; reads forward from the write buffer.
// No backpressure: one write and one read accepted every cycle, reads fully pipelined.
module subservient_sram_bridge
  import subservient_sram_pkg::*;
#(
  parameter  int MEMSIZE  = DEF_MEMSIZE,
  parameter  int NARROW_W = DEF_NARROW_W,
  parameter  int MACRO_DW = DEF_MACRO_DW,
  parameter  int MACRO_AW = DEF_MACRO_AW,
  localparam int NU       = MACRO_DW / NARROW_W,
  localparam int NBK      = bank_count(MEMSIZE, MACRO_DW, MACRO_AW),
  localparam int ADDR_W   = $clog2(MEMSIZE * 8 / NARROW_W),
  localparam int WMW      = MACRO_DW / 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [NARROW_W-1:0]     i_wdata,
  input  logic                    i_wen,
  input  logic [ADDR_W-1:0]       i_raddr,
  input  logic                    i_ren,
  output logic [NARROW_W-1:0]     o_rdata,
  output logic                    o_rvalid,
  output logic [NBK-1:0]          o_csb0,
  output logic [WMW-1:0]          o_wmask0,
  output logic [MACRO_AW-1:0]     o_addr0,
  output logic [MACRO_DW-1:0]     o_din0,
  output logic [NBK-1:0]          o_csb1,
  output logic [MACRO_AW-1:0]     o_addr1,
  input  logic [NBK*MACRO_DW-1:0] i_dout1
);

  localparam int UL     = field_bits(NU);
  localparam int UW     = (UL > 0) ? UL : 1;
  localparam int BL     = field_bits(NBK);
  localparam int BW     = (BL > 0) ? BL : 1;
  localparam int WORD_W = ADDR_W - UL;

  logic [WORD_W-1:0]   w_wword, w_rword, w_buf_word;
  logic [UW-1:0]       w_wunit, w_runit;
  logic [BW-1:0]       w_rbank;
  logic                w_buf_valid, w_fwd, w_out_vld;
  logic [MACRO_DW-1:0] w_buf_data, w_macro_word;
  logic [NU-1:0]       w_buf_umask;
  logic [NARROW_W-1:0] w_fwd_data, w_macro_unit, w_sel;

  logic                r_rv1, r_fwd1;
  logic [BW-1:0]       r_rbank1;
  logic [UW-1:0]       r_runit1;
  logic [NARROW_W-1:0] r_fdata1;

  assign w_wword = i_waddr[ADDR_W-1:UL];
  assign w_rword = i_raddr[ADDR_W-1:UL];

  if (NU > 1) begin : g_unit
    assign w_wunit = i_waddr[UL-1:0];
    assign w_runit = i_raddr[UL-1:0];
  end else begin : g_nounit
    assign w_wunit = '0;
    assign w_runit = '0;
  end

  if (NBK > 1) begin : g_bank
    assign w_rbank = w_rword[WORD_W-1:MACRO_AW];
  end else begin : g_nobank
    assign w_rbank = '0;
  end

  subservient_sram_wcomb #(
    .NARROW_W (NARROW_W),
    .MACRO_DW (MACRO_DW),
    .MACRO_AW (MACRO_AW),
    .NBK      (NBK),
    .NU       (NU),
    .UW       (UW),
    .BW       (BW),
    .WORD_W   (WORD_W),
    .WMW      (WMW)
  ) u_wcomb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wen       (i_wen),
    .i_wword     (w_wword),
    .i_wunit     (w_wunit),
    .i_wdata     (i_wdata),
    .o_buf_valid (w_buf_valid),
    .o_buf_word  (w_buf_word),
    .o_buf_data  (w_buf_data),
    .o_buf_umask (w_buf_umask),
    .o_csb0      (o_csb0),
    .o_wmask0    (o_wmask0),
    .o_addr0     (o_addr0),
    .o_din0      (o_din0)
  );

  // Port1 issues the macro read in the request cycle; held off during reset
  assign o_addr1 = w_rword[MACRO_AW-1:0];
  assign o_csb1  = (i_ren & ~i_rst) ? ~(NBK'(1) << w_rbank) : '1;

  // Buffered unit overrides the macro when it holds a write not yet in the array
  assign w_fwd      = i_ren & w_buf_valid & (w_buf_word == w_rword) & w_buf_umask[w_runit];
  assign w_fwd_data = w_buf_data[w_runit*NARROW_W +: NARROW_W];

  // Capture read selects and the forwarding decision in the request cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rv1    <= 1'b0;
      r_fwd1   <= 1'b0;
      r_rbank1 <= '0;
      r_runit1 <= '0;
      r_fdata1 <= '0;
    end else begin
      r_rv1    <= i_ren;
      r_fwd1   <= w_fwd;
      r_rbank1 <= w_rbank;
      r_runit1 <= w_runit;
      r_fdata1 <= w_fwd_data;
    end
  end

  assign w_macro_word = i_dout1[r_rbank1*MACRO_DW +: MACRO_DW];
  assign w_macro_unit = w_macro_word[r_runit1*NARROW_W +: NARROW_W];
  assign w_sel        = r_fwd1 ? r_fdata1 : w_macro_unit;

`ifdef SRAM_RDREG_EN
  logic                r_rv2;
  logic [NARROW_W-1:0] r_rd2;

  // Extra register on the selected read data for timing into the consumer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rv2 <= 1'b0;
      r_rd2 <= '0;
    end else begin
      r_rv2 <= r_rv1;
      r_rd2 <= r_rv1 ? w_sel : '0;
    end
  end

  assign w_out_vld = r_rv2 & ~i_rst;
  assign o_rdata   = w_out_vld ? r_rd2 : '0;
`else
  assign w_out_vld = r_rv1 & ~i_rst;
  assign o_rdata   = w_out_vld ? w_sel : '0;
`endif

  assign o_rvalid = w_out_vld;

endmodule

// File: tb/tb_subservient_sram_bridge.sv
module tb_subservient_sram_bridge;

`ifdef SRAM_RDREG_EN
  localparam int RL = 2;
`else
  localparam int RL = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-geometry instance: 8 banks, 8-bit narrow port
  logic        rst = 1'b1;
  logic [12:0] waddr = '0, raddr = '0;
  logic [7:0]  wdata = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [7:0]  csb0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;
  logic [255:0] dout1;

  subservient_sram_bridge dut (
    .i_clk(clk), .i_rst(rst), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
    .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_csb0(csb0), .o_wmask0(wmask0), .o_addr0(addr0), .o_din0(din0),
    .o_csb1(csb1), .o_addr1(addr1), .i_dout1(dout1)
  );

  // 16-bit narrow port, 2 KiB -> 2 banks
  logic [9:0]  waddr2 = '0, raddr2 = '0;
  logic [15:0] wdata2 = '0;
  logic        wen2 = 1'b0, ren2 = 1'b0;
  logic [15:0] rdata2;
  logic        rvalid2;
  logic [1:0]  csb0_2, csb1_2;
  logic [3:0]  wmask0_2;
  logic [7:0]  addr0_2, addr1_2;
  logic [31:0] din0_2;
  logic [63:0] dout1_2 = '0;

  subservient_sram_bridge #(.MEMSIZE(2048), .NARROW_W(16)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_waddr(waddr2), .i_wdata(wdata2), .i_wen(wen2),
    .i_raddr(raddr2), .i_ren(ren2), .o_rdata(rdata2), .o_rvalid(rvalid2),
    .o_csb0(csb0_2), .o_wmask0(wmask0_2), .o_addr0(addr0_2), .o_din0(din0_2),
    .o_csb1(csb1_2), .o_addr1(addr1_2), .i_dout1(dout1_2)
  );

  // Behavioural 1rw1r macro array for the default instance (read-before-write)
  logic [31:0] mem [8][256];
  logic [31:0] mdout [8];
  int wr_cnt = 0;

  initial begin
    for (int b = 0; b < 8; b++) begin
      mdout[b] = '0;
      for (int a = 0; a < 256; a++) mem[b][a] = '0;
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      logic [31:0] nw;
      if (!csb1[b]) mdout[b] <= mem[b][addr1];
      if (!csb0[b]) begin
        nw = mem[b][addr0];
        for (int l = 0; l < 4; l++) if (wmask0[l]) nw[l*8 +: 8] = din0[l*8 +: 8];
        mem[b][addr0] <= nw;
      end
    end
    if (csb0 != 8'hFF) wr_cnt <= wr_cnt + 1;
  end

  always_comb for (int b = 0; b < 8; b++) dout1[b*32 +: 32] = mdout[b];

  int checks = 0;
  int failures = 0;

  task automatic step(input logic r, input logic w, input logic [12:0] wa, input logic [7:0] wd,
                      input logic rd, input logic [12:0] ra);
    @(negedge clk);
    rst = r; wen = w; waddr = wa; wdata = wd; ren = rd; raddr = ra;
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 13'h0004);
    checks++; if (csb0 !== 8'hFF) begin failures++; $display("FAIL reset_csb0 got=%h exp=ff", csb0); end
    checks++; if (csb1 !== 8'hFF) begin failures++; $display("FAIL reset_csb1 got=%h exp=ff", csb1); end
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    checks++; if (csb0_2 !== 2'b11) begin failures++; $display("FAIL reset_csb0_2 got=%b exp=11", csb0_2); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid_after got=%b exp=0", rvalid); end
  endtask

  task automatic test_combine();
    int cnt0;
    logic [7:0] d [4];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    cnt0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 13'(4 + i), d[i], 0, 0);
      checks++; if (csb0 !== 8'hFF) begin failures++; $display("FAIL combine_merge_csb0 i=%0d got=%h exp=ff", i, csb0); end
    end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (csb0 !== 8'hFE) begin failures++; $display("FAIL combine_csb0 got=%h exp=fe", csb0); end
    checks++; if (addr0 !== 8'h01) begin failures++; $display("FAIL combine_addr0 got=%h exp=01", addr0); end
    checks++; if (wmask0 !== 4'hF) begin failures++; $display("FAIL combine_wmask0 got=%h exp=f", wmask0); end
    checks++; if (din0 !== 32'h44332211) begin failures++; $display("FAIL combine_din0 got=%h exp=44332211", din0); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (csb0 !== 8'hFF) begin failures++; $display("FAIL combine_idle_csb0 got=%h exp=ff", csb0); end
    checks++; if (addr0 !== 8'h01) begin failures++; $display("FAIL combine_hold_addr0 got=%h exp=01", addr0); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (wr_cnt !== cnt0 + 1) begin failures++; $display("FAIL combine_write_count got=%0d exp=%0d", wr_cnt - cnt0, 1); end
    for (int c = 0; c <= RL; c++) begin
      step(0, 0, 0, 0, c == 0, 13'h0006);
      if (c == 0) begin
        checks++; if (rvalid !== 1'b0) begin failures++; $display("FAIL combine_rd_early got=%b exp=0", rvalid); end
      end
      if (c == RL) begin
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h33) begin failures++; $display("FAIL combine_rd got=%b/%h exp=1/33", rvalid, rdata); end
      end
    end
  endtask

  task automatic test_forward();
    step(0, 1, 13'h1404, 8'hA5, 0, 0);
    for (int c = 0; c <= RL; c++) begin
      step(0, 0, 0, 0, c == 0, 13'h1404);
      if (c == 0) begin
        checks++; if (csb1 !== 8'hDF) begin failures++; $display("FAIL fwd_csb1 got=%h exp=df", csb1); end
        checks++; if (csb0 !== 8'hDF) begin failures++; $display("FAIL fwd_flush_csb0 got=%h exp=df", csb0); end
      end
      if (c == RL) begin
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hA5) begin failures++; $display("FAIL fwd_rdata got=%b/%h exp=1/a5", rvalid, rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 13'h0010, 8'h01, 0, 0);
    checks++; if (csb0 !== 8'hFF) begin failures++; $display("FAIL b2b_first_csb0 got=%h exp=ff", csb0); end
    step(0, 1, 13'h0020, 8'h02, 0, 0);
    checks++; if (csb0 !== 8'hFE || addr0 !== 8'h04) begin failures++; $display("FAIL b2b_flush1 got=%h/%h exp=fe/04", csb0, addr0); end
    checks++; if (wmask0 !== 4'h1 || din0[7:0] !== 8'h01) begin failures++; $display("FAIL b2b_flush1_data got=%h/%h exp=1/01", wmask0, din0[7:0]); end
    step(0, 0, 0, 0, 0, 0);
    checks++; if (csb0 !== 8'hFE || addr0 !== 8'h08) begin failures++; $display("FAIL b2b_flush2 got=%h/%h exp=fe/08", csb0, addr0); end
    checks++; if (wmask0 !== 4'h1 || din0[7:0] !== 8'h02) begin failures++; $display("FAIL b2b_flush2_data got=%h/%h exp=1/02", wmask0, din0[7:0]); end
    for (int c = 0; c <= RL + 1; c++) begin
      step(0, 0, 0, 0, c < 2, (c == 0) ? 13'h0010 : 13'h0020);
      if (c == RL) begin
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h01) begin failures++; $display("FAIL b2b_rd0 got=%b/%h exp=1/01", rvalid, rdata); end
      end
      if (c == RL + 1) begin
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h02) begin failures++; $display("FAIL b2b_rd1 got=%b/%h exp=1/02", rvalid, rdata); end
      end
    end
  endtask

  task automatic test_same_cycle();
    step(0, 1, 13'h0008, 8'h5A, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int c = 0; c <= RL + 1; c++) begin
      step(0, c == 0, 13'h0008, 8'hFF, c < 2, 13'h0008);
      if (c == RL) begin
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h5A) begin failures++; $display("FAIL same_cycle_old got=%b/%h exp=1/5a", rvalid, rdata); end
      end
      if (c == RL + 1) begin
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hFF) begin failures++; $display("FAIL same_cycle_new got=%b/%h exp=1/ff", rvalid, rdata); end
      end
    end
  endtask

  task automatic test_reset_inflight();
    int cnt0;
    step(0, 0, 0, 0, 0, 0);
    cnt0 = wr_cnt;
    step(0, 1, 13'h0040, 8'h77, 1, 13'h0044);
    step(1, 0, 0, 0, 0, 0);
    checks++; if (csb0 !== 8'hFF || csb1 !== 8'hFF) begin failures++; $display("FAIL rst_inflight_csb got=%h/%h exp=ff/ff", csb0, csb1); end
    checks++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin failures++; $display("FAIL rst_inflight_rd got=%b/%h exp=0/00", rvalid, rdata); end
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0, 0);
      checks++; if (csb0 !== 8'hFF || rvalid !== 1'b0) begin failures++; $display("FAIL rst_after c=%0d got=%h/%b exp=ff/0", c, csb0, rvalid); end
    end
    checks++; if (wr_cnt !== cnt0) begin failures++; $display("FAIL rst_no_write got=%0d exp=0", wr_cnt - cnt0); end
    for (int c = 0; c <= RL; c++) begin
      step(0, 0, 0, 0, c == 0, 13'h0040);
      if (c == RL) begin
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h00) begin failures++; $display("FAIL rst_discard got=%b/%h exp=1/00", rvalid, rdata); end
      end
    end
  endtask

  task automatic test_wide();
    @(negedge clk);
    wen2 = 1'b1; waddr2 = 10'h003; wdata2 = 16'hBEEF;
    #1;
    checks++; if (csb0_2 !== 2'b11) begin failures++; $display("FAIL wide_load_csb0 got=%b exp=11", csb0_2); end
    @(negedge clk);
    wen2 = 1'b0;
    #1;
    checks++; if (csb0_2 !== 2'b10) begin failures++; $display("FAIL wide_csb0 got=%b exp=10", csb0_2); end
    checks++; if (wmask0_2 !== 4'hC) begin failures++; $display("FAIL wide_wmask0 got=%h exp=c", wmask0_2); end
    checks++; if (din0_2[31:16] !== 16'hBEEF) begin failures++; $display("FAIL wide_din0 got=%h exp=beef", din0_2[31:16]); end
    checks++; if (addr0_2 !== 8'h01) begin failures++; $display("FAIL wide_addr0 got=%h exp=01", addr0_2); end
    @(negedge clk);
    #1;
    checks++; if (csb0_2 !== 2'b11) begin failures++; $display("FAIL wide_idle_csb0 got=%b exp=11", csb0_2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_combine();
    test_forward();
    test_back_to_back();
    test_same_cycle();
    test_reset_inflight();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subservient_sram_bridge.md
Name: subservient_sram_bridge

Overview:
- Parametrised bridge between the subservient narrow SRAM port (separate write/read, 1 unit per access) and NB banks of 1rw1r OpenRAM macros.
- Generalises the single-macro byte adapter in three ways:
  - configurable narrow width, memory size and macro geometry;
  - a write-combining buffer that merges narrow writes to one macro word into a single masked write;
  - coherent read forwarding out of that buffer.
- Sits between subservient and the macro array inside user_proj_top.

Parameters:
- MEMSIZE, 8192, total bytes; power of two, multiple of one macro's capacity.
- NARROW_W, 8, narrow data width; one of 8, 16, 32.
- MACRO_DW, 32, macro word width; multiple of NARROW_W.
- MACRO_AW, 8, macro word-address bits (256 words).
- Derived, not overridable:
  - U = MACRO_DW/NARROW_W, narrow units per word.
  - NB = MEMSIZE*8/(MACRO_DW<<MACRO_AW), bank count.
  - AW = clog2(MEMSIZE*8/NARROW_W), narrow address width.
  - WM = MACRO_DW/8, macro wmask width.

Ports:
- i_clk  in  1  clock, also drives the macro clk0/clk1.
- i_rst  in  1  reset, synchronous, active-high.
- i_waddr  in  AW  narrow write address.
- i_wdata  in  NARROW_W  write data.
- i_wen  in  1  write strobe.
- i_raddr  in  AW  narrow read address.
- i_ren  in  1  read strobe.
- o_rdata  out  NARROW_W  read data.
- o_rvalid  out  1  read data valid.
- o_csb0  out  NB  port0 chip selects, active-low.
- o_wmask0  out  WM  port0 byte mask.
- o_addr0  out  MACRO_AW  port0 address.
- o_din0  out  MACRO_DW  port0 write data.
- o_csb1  out  NB  port1 chip selects, active-low.
- o_addr1  out  MACRO_AW  port1 address.
- i_dout1  in  NB*MACRO_DW  port1 read data, bank b at [b*MACRO_DW +: MACRO_DW].

Behaviour:
- Address split for both ports:
  - unit = addr[clog2(U)-1:0];
  - word = addr[AW-1:clog2(U)];
  - bank = word[MACRO_AW +: clog2(NB)];
  - macro address = word[MACRO_AW-1:0].
  - With NB=1 the bank field is absent; with U=1 the unit field is absent.
- Write-combining buffer registers: buf_valid, buf_word, buf_data[MACRO_DW], buf_umask[U].
- Each cycle, in priority order:
  - i_wen with buf_valid and word==buf_word: merge. Set umask bit, write the unit slice of buf_data. No macro write.
  - Flush (buf_valid and, in the same cycle, no i_wen or a different word): drive port0 from buf_*.
    - o_csb0[bank] low, all other banks high.
    - o_wmask0 = each umask bit expanded to NARROW_W/8 lanes.
    - o_din0 = buf_data.
  - i_wen with a new word: load the buffer (umask one-hot, buf_valid=1). This may happen in the same cycle as a flush of the old word.
  - Otherwise clear buf_valid.
- At most one macro write per cycle. Port0 writes only; web0 is tied at top level.
- Idle port0: o_csb0 all-ones; o_addr0, o_din0 and o_wmask0 hold their previous values.
- Read issued at cycle T:
  - o_csb1[bank] low at T; macro data arrives at T+1.
  - o_rvalid=1 and o_rdata valid at T+1.
  - The bank and unit selects used to pick o_rdata are registered at T.
- Read coherence: a read at T returns the effect of every write with i_wen asserted in cycles before T. A same-cycle write is not visible.
  - Forwarding condition, decided at T: buf_valid, buf_word==read word, and buf_umask[unit] set.
  - When it holds, o_rdata at T+1 comes from the buf_data unit captured at T, not from the macro.
  - This also covers a flush and a read of the same word in the same cycle (macro read result undefined).
- Back-to-back reads: one per cycle, fully pipelined.
- Simultaneous i_wen and i_ren to different banks or words: independent.
- Reset:
  - buf_valid=0 and o_rvalid=0; buffered unflushed data is discarded.
  - o_csb0=o_csb1=all-ones; o_rdata=0.
  - A read in flight during the reset cycle produces no o_rvalid.

Optional Feature:
- Macro: SRAM_RDREG_EN.
- Defined:
  - i_dout1 selection is registered one more stage;
  - o_rvalid/o_rdata arrive at T+2;
  - the forwarding decision is still taken at T and carried two stages.
- Undefined: latency T+1 as above.
- The consumer must qualify read data with o_rvalid.

Decomposition:
- Package subservient_sram_pkg holds:
  - lane-expansion and bank-count functions;
  - the derived-width localparams U, NB, AW, WM;
  - the buffer state struct typedef.
- One sub-module, subservient_sram_wcomb: buffer registers, merge/flush decision, port0 drive.
- Top handles address split, port1, forwarding and the read pipeline.

Test Plan:
- Defaults. Writes to 0x004..0x007 with data 11,22,33,44 on consecutive cycles, then idle. Required:
  - exactly one port0 write: bank 0, addr0=1, wmask0=4'hF, din0=32'h44332211;
  - a subsequent read of 0x006 returns 8'h33 at T+1.
- Write 8'hA5 to 0x1404, then read 0x1404 the very next cycle, before the flush completes. Required: o_rdata=8'hA5 is forwarded; a macro read of bank 5 is issued but ignored.
- Write 0x0010 then 0x0020 on back-to-back cycles. Required:
  - flush of word 4 happens in the same cycle as the buffer loads word 8;
  - wmask0=4'h1, then 4'h1 on the next flush.
- Simultaneous write and read of 0x0008 (previously holding 8'h5A, new data 8'hFF). Required: read returns 8'h5A; a read at the next cycle returns 8'hFF.
- NARROW_W=16, MEMSIZE=2048. Write 16'hBEEF to unit address 0x003, then idle. Required: NB=2, wmask0=4'hC, din0[31:16]=16'hBEEF, csb0=2'b10.
- Assert i_rst for one cycle while the buffer is valid and a read is in flight. Required: no port0 write afterwards, no o_rvalid, all csb outputs high.
